osc_poly: RTL

//  N-voice phase-accumulator oscillator bank, successor to the single-voice osc block.
//  One shared adder is time-multiplexed across voices once per sample strobe.
//  Per-voice increment, waveform mode and enable are set through a register write port.

---
 rtl/osc_poly.sv | 137 +++++++++++++
 1 files changed

// File: rtl/osc_poly.sv
// osc_poly: N-voice phase-accumulator oscillator bank, one shared adder swept across voices per strobe.
// Optional noise generator for mode 3 is built when OSC_POLY_NOISE_EN is defined.
module osc_poly #(
    parameter  int unsigned VOICES = 4,
    parameter  int unsigned ACC_W  = 24,
    parameter  int unsigned OUT_W  = 8,
    localparam int unsigned VIDX_W = $clog2(VOICES),
    localparam int unsigned MIX_W  = OUT_W + $clog2(VOICES)
) (
    input  logic              clk_i,
    input  logic              nrst_i,
    input  logic              enable_i,
    input  logic              sample_stb_i,
    input  logic              cfg_we_i,
    input  logic [VIDX_W-1:0] cfg_voice_i,
    input  logic [ACC_W-1:0]  cfg_inc_i,
    input  logic [1:0]        cfg_mode_i,
    input  logic              cfg_en_i,
    input  logic [VOICES-1:0] phase_rst_i,
    input  logic              ovr_clr_i,
    output logic [MIX_W-1:0]  mix_o,
    output logic              mix_valid_o,
    output logic              busy_o,
    output logic              overrun_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic [VIDX_W-1:0] vcnt;
    logic [ACC_W-1:0]  phase [VOICES];
    logic [ACC_W-1:0]  inc   [VOICES];
    logic [1:0]        mode  [VOICES];
    logic [VOICES-1:0] ven;
    logic [MIX_W-1:0]  acc;
    logic              start, slot_last;
    logic [ACC_W-1:0]  p_upd;
    logic [OUT_W-1:0]  t, wave, noise;

    assign start     = (state == IDLE) && sample_stb_i && enable_i;
    assign slot_last = (vcnt == VIDX_W'(VOICES - 1));
    assign busy_o    = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (slot_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shared adder: only the voice in the current slot is advanced.
    always_comb begin
        if (phase_rst_i[vcnt])
            p_upd = '0;
        else if (ven[vcnt])
            p_upd = phase[vcnt] + inc[vcnt];
        else
            p_upd = phase[vcnt];
        t = p_upd[ACC_W-2 -: OUT_W];
        case (mode[vcnt])
            2'd0:    wave = p_upd[ACC_W-1] ? '1 : '0;
            2'd1:    wave = p_upd[ACC_W-1 -: OUT_W];
            2'd2:    wave = p_upd[ACC_W-1] ? ~t : t;
            default: wave = noise;
        endcase
        if (!ven[vcnt])
            wave = '0;
    end

`ifdef OSC_POLY_NOISE_EN
    logic [15:0] lfsr, lfsr_nxt;

    assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign noise    = lfsr_nxt[15 -: OUT_W];

    always_ff @(posedge clk_i) begin
        if (!nrst_i)
            lfsr <= 16'hACE1;
        else if (state == RUN && ven[vcnt] && mode[vcnt] == 2'd3)
            lfsr <= lfsr_nxt;
    end
`else
    assign noise = '0;
`endif

    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            state       <= IDLE;
            vcnt        <= '0;
            acc         <= '0;
            mix_o       <= '0;
            mix_valid_o <= 1'b0;
            overrun_o   <= 1'b0;
            ven         <= '0;
            for (int unsigned i = 0; i < VOICES; i++) begin
                phase[i] <= '0;
                inc[i]   <= '0;
                mode[i]  <= '0;
            end
        end else begin
            state       <= state_nxt;
            mix_valid_o <= 1'b0;
            if (start) begin
                acc  <= '0;
                vcnt <= '0;
            end
            if (state == RUN) begin
                acc  <= acc + MIX_W'(wave);
                vcnt <= slot_last ? '0 : vcnt + 1'b1;
            end
            if (state == DONE) begin
                mix_o       <= acc;
                mix_valid_o <= 1'b1;
            end
            // Set wins over clear so an overrun is never lost.
            if (sample_stb_i && state != IDLE)
                overrun_o <= 1'b1;
            else if (ovr_clr_i)
                overrun_o <= 1'b0;
            for (int unsigned i = 0; i < VOICES; i++) begin
                if (phase_rst_i[i])
                    phase[i] <= '0;
                else if (state == RUN && vcnt == VIDX_W'(i))
                    phase[i] <= p_upd;
            end
            if (cfg_we_i && {1'b0, cfg_voice_i} < (VIDX_W + 1)'(VOICES)) begin
                inc[cfg_voice_i]  <= cfg_inc_i;
                mode[cfg_voice_i] <= cfg_mode_i;
                ven[cfg_voice_i]  <= cfg_en_i;
            end
        end
    end

endmodule
